wave_frame_reader: RTL and testbench

Read side of the DSO sample buffer. Once the sampler has committed a triggered capture, this block locks a read base address centred on the trigger sample. It then serves per-column sample reads from the 1024-deep sample RAM to the HDMI waveform renderer for one whole frame. At the end of each drawn frame it returns `wr_over` to the sampler so the sampler can re-arm acquisition.

---
 rtl/wave_frame_reader_if.sv | 33 +++
 rtl/wave_frame_reader.sv | 105 ++++++++++
 tb/tb_wave_frame_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/wave_frame_reader_if.sv
// Bus between the sample-RAM read side, the sampler trigger handshake and the
// waveform renderer. The slave modport is the frame reader itself.
interface wave_frame_reader_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          wave_run;
  logic          buf_trig;
  logic [AW-1:0] buf_trig_addr;
  logic          frame_start;
  logic          frame_end;
  logic          col_req;
  logic [AW-1:0] col_x;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          col_valid;
  logic [DW-1:0] col_data;
  logic          frame_locked;
  logic          wr_over;

  modport slave (
    input  wave_run, buf_trig, buf_trig_addr, frame_start, frame_end,
           col_req, col_x, rd_data,
    output rd_en, rd_addr, col_valid, col_data, frame_locked, wr_over
  );

  modport master (
    output wave_run, buf_trig, buf_trig_addr, frame_start, frame_end,
           col_req, col_x, rd_data,
    input  rd_en, rd_addr, col_valid, col_data, frame_locked, wr_over
  );
endinterface

// File: rtl/wave_frame_reader.sv
// Locks a read base centred on the trigger sample and serves per-column
// sample reads to the renderer, returning wr_over after each drawn frame.
module wave_frame_reader #(
  parameter int WAVE_DEPTH      = 1024,
  parameter int HALF_WAVE_DEPTH = WAVE_DEPTH >> 1,
  parameter int DISP_WIDTH      = 1000
) (
  input  logic               clk,
  input  logic               rst,
  wave_frame_reader_if.slave bus
);
  localparam int AW = $clog2(WAVE_DEPTH);
  localparam logic [AW-1:0] HALF_OFS   = AW'(HALF_WAVE_DEPTH);
  localparam logic [AW:0]   DISP_LIMIT = (AW+1)'(DISP_WIDTH);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    LOCKED  = 2'd1,
    DRAWING = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_base_addr;
  logic          r_frame_locked;
  logic          r_wr_over;

  logic          r_s1_valid;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_col_valid;
  logic          r_s2_in_range;

  logic          w_col_in_range;
  logic [AW-1:0] w_col_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ARMED;
      r_base_addr    <= '0;
      r_frame_locked <= 1'b0;
      r_wr_over      <= 1'b0;
    end else begin
      r_wr_over <= 1'b0;
      case (r_state)
        ARMED: begin
          if (bus.buf_trig && bus.wave_run) begin
            r_base_addr <= bus.buf_trig_addr - HALF_OFS;
            r_state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_start) begin
            r_state        <= DRAWING;
            r_frame_locked <= 1'b1;
          end
        end
        DRAWING: begin
          // frame_end takes priority over a coincident frame_start
          if (bus.frame_end) begin
            r_frame_locked <= 1'b0;
            if (bus.wave_run) begin
              r_wr_over <= 1'b1;
              r_state   <= ARMED;
            end else begin
              r_state <= LOCKED;
            end
          end
        end
        default: begin
          r_state        <= ARMED;
          r_frame_locked <= 1'b0;
        end
      endcase
    end
  end

  assign w_col_in_range = ({1'b0, bus.col_x} < DISP_LIMIT);
  assign w_col_addr     = r_base_addr + bus.col_x;

  // Two-stage column pipeline: address issue, then RAM data return
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_col_valid   <= 1'b0;
      r_s2_in_range <= 1'b0;
    end else begin
      r_s1_valid    <= bus.col_req;
      r_rd_en       <= bus.col_req && w_col_in_range;
      if (bus.col_req) begin
        r_rd_addr <= w_col_addr;
      end
      r_col_valid   <= r_s1_valid;
      r_s2_in_range <= r_rd_en;
    end
  end

  assign bus.rd_en        = r_rd_en;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.col_valid    = r_col_valid;
  assign bus.col_data     = r_s2_in_range ? bus.rd_data : '0;
  assign bus.frame_locked = r_frame_locked;
  assign bus.wr_over      = r_wr_over;
endmodule

// File: tb/tb_wave_frame_reader.sv
// Bench for wave_frame_reader: directed vector table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_wave_frame_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_frame_reader_if bus();

  wave_frame_reader #(
    .WAVE_DEPTH(1024),
    .HALF_WAVE_DEPTH(512),
    .DISP_WIDTH(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) bus.rd_data <= mem[bus.rd_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: spec-level state, trigger-centred base, request history
  typedef enum {M_ARMED, M_LOCKED, M_DRAWING} mstate_t;
  typedef struct {
    bit v;
    bit ok;
    int addr;
  } req_t;

  mstate_t m_state;
  int      m_base;
  bit      m_wr;
  req_t    p1, p2;

  task automatic tick();
    req_t nr;
    bit   n_wr;
    nr.v    = bus.col_req;
    nr.ok   = (int'(bus.col_x) < 1000);
    nr.addr = (m_base + int'(bus.col_x)) % 1024;
    n_wr    = 1'b0;
    if (rst) begin
      m_state = M_ARMED;
      m_base  = 0;
      p1      = '{0, 0, 0};
      p2      = '{0, 0, 0};
    end else begin
      p2 = p1;
      p1 = nr;
      case (m_state)
        M_ARMED:
          if (bus.buf_trig && bus.wave_run) begin
            m_base  = (int'(bus.buf_trig_addr) + 1024 - 512) % 1024;
            m_state = M_LOCKED;
          end
        M_LOCKED:
          if (bus.frame_start) m_state = M_DRAWING;
        default:
          if (bus.frame_end) begin
            if (bus.wave_run) begin
              n_wr    = 1'b1;
              m_state = M_ARMED;
            end else begin
              m_state = M_LOCKED;
            end
          end
      endcase
    end
    m_wr = n_wr;
    @(posedge clk);
    #1;
    check("rd_en", 32'(bus.rd_en), 32'(p1.v && p1.ok));
    if (p1.v && p1.ok) check("rd_addr", 32'(bus.rd_addr), 32'(p1.addr));
    check("col_valid", 32'(bus.col_valid), 32'(p2.v));
    check("col_data", 32'(bus.col_data), (p2.v && p2.ok) ? 32'(mem[p2.addr]) : 32'd0);
    check("frame_locked", 32'(bus.frame_locked), 32'(m_state == M_DRAWING));
    check("wr_over", 32'(bus.wr_over), 32'(m_wr));
    rst             = 1'b0;
    bus.buf_trig    = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.col_req     = 1'b0;
  endtask

  typedef struct {
    logic [9:0] trig_addr;
    logic [9:0] col_x;
    bit         exp_en;
    logic [9:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    m_state = M_ARMED;
    m_base  = 0;
    m_wr    = 1'b0;
    p1 = '{0, 0, 0};
    p2 = '{0, 0, 0};
    rst = 1'b1;
    bus.wave_run = 1'b0; bus.buf_trig = 1'b0; bus.buf_trig_addr = '0;
    bus.frame_start = 1'b0; bus.frame_end = 1'b0; bus.col_req = 1'b0; bus.col_x = '0;

    vecs[0] = '{10'd600, 10'd0,    1'b1, 10'd88};
    vecs[1] = '{10'd600, 10'd1,    1'b1, 10'd89};
    vecs[2] = '{10'd600, 10'd2,    1'b1, 10'd90};
    vecs[3] = '{10'd100, 10'd411,  1'b1, 10'd1023};
    vecs[4] = '{10'd100, 10'd412,  1'b1, 10'd0};
    vecs[5] = '{10'd100, 10'd1000, 1'b0, 10'd0};
    vecs[6] = '{10'd512, 10'd1023, 1'b0, 10'd0};
    vecs[7] = '{10'd0,   10'd999,  1'b1, 10'd487};

    tick();
    check("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("reset_col_data", 32'(bus.col_data), 32'd0);

    // Directed lock/wrap vectors
    for (int i = 0; i < 8; i++) begin
      rst = 1'b1; tick();
      bus.wave_run = 1'b1; bus.buf_trig = 1'b1; bus.buf_trig_addr = vecs[i].trig_addr; tick();
      bus.frame_start = 1'b1; tick();
      check("vec_locked", 32'(bus.frame_locked), 32'd1);
      bus.col_req = 1'b1; bus.col_x = vecs[i].col_x; tick();
      check("vec_rd_en", 32'(bus.rd_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) check("vec_rd_addr", 32'(bus.rd_addr), 32'(vecs[i].exp_addr));
      tick();
      check("vec_col_valid", 32'(bus.col_valid), 32'd1);
      check("vec_col_data", 32'(bus.col_data),
            vecs[i].exp_en ? 32'(mem[vecs[i].exp_addr]) : 32'd0);
    end

    // Back-to-back columns, then frame handshake
    rst = 1'b1; tick();
    bus.wave_run = 1'b1; bus.buf_trig = 1'b1; bus.buf_trig_addr = 10'd600; tick();
    bus.frame_start = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      bus.col_req = 1'b1; bus.col_x = 10'(i); tick();
      check("b2b_rd_addr", 32'(bus.rd_addr), 32'(88 + i));
    end
    tick(); tick();
    bus.frame_end = 1'b1; tick();
    check("hs_wr_over", 32'(bus.wr_over), 32'd1);
    tick();
    check("hs_wr_over_drop", 32'(bus.wr_over), 32'd0);
    bus.frame_end = 1'b1; tick();
    check("hs_second_end", 32'(bus.wr_over), 32'd0);

    // STOP hold: same capture redrawn, new triggers ignored
    bus.buf_trig = 1'b1; bus.buf_trig_addr = 10'd300; tick();
    bus.frame_start = 1'b1; tick();
    bus.wave_run = 1'b0; bus.frame_end = 1'b1; tick();
    check("stop_wr_over", 32'(bus.wr_over), 32'd0);
    bus.frame_start = 1'b1; tick();
    check("stop_relock", 32'(bus.frame_locked), 32'd1);
    bus.buf_trig = 1'b1; bus.buf_trig_addr = 10'd5; tick();
    bus.col_req = 1'b1; bus.col_x = 10'd0; tick();
    check("stop_base", 32'(bus.rd_addr), 32'd812);
    bus.wave_run = 1'b1; bus.frame_end = 1'b1; tick();
    check("stop_release", 32'(bus.wr_over), 32'd1);

    // Simultaneous trigger + frame_start, then frame_end + frame_start
    bus.buf_trig = 1'b1; bus.buf_trig_addr = 10'd700; bus.frame_start = 1'b1; tick();
    check("sim_no_lock", 32'(bus.frame_locked), 32'd0);
    tick();
    check("sim_no_lock2", 32'(bus.frame_locked), 32'd0);
    bus.frame_start = 1'b1; tick();
    check("sim_lock", 32'(bus.frame_locked), 32'd1);
    bus.frame_end = 1'b1; bus.frame_start = 1'b1; tick();
    check("sim_end_wins", 32'(bus.wr_over), 32'd1);
    bus.frame_start = 1'b1; tick();
    check("sim_armed", 32'(bus.frame_locked), 32'd0);

    // Reset with two requests in flight
    bus.col_req = 1'b1; bus.col_x = 10'd10; tick();
    bus.col_req = 1'b1; bus.col_x = 10'd11; tick();
    rst = 1'b1; tick();
    check("rst_col_valid", 32'(bus.col_valid), 32'd0);
    tick();
    check("rst_col_valid2", 32'(bus.col_valid), 32'd0);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_wr_over", 32'(bus.wr_over), 32'd0);
    bus.col_req = 1'b1; bus.col_x = 10'd7; tick();
    check("rst_base_zero", 32'(bus.rd_addr), 32'd7);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.wave_run = 1'($urandom);
      bus.buf_trig      = ($urandom_range(0, 15) == 0);
      bus.buf_trig_addr = 10'($urandom);
      bus.frame_start   = ($urandom_range(0, 31) == 0);
      bus.frame_end     = ($urandom_range(0, 31) == 0);
      bus.col_req       = ($urandom_range(0, 3) != 0);
      bus.col_x         = 10'($urandom_range(0, 1023));
      rst               = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
